simon_serial_pad_if: RTL and testbench

- Pad-limited successor to the wide parallel Simon 32/64 pad wrapper.
- Plaintext and key enter over a narrow, parametrised, valid/ready input bus. Ciphertext leaves over a matching output bus.
- Encryption runs in an internal iterative round engine at one round per cycle, with on-the-fly key expansion.
- Adds two features: key retention across frames (key-reuse frames) and a reduced-round mode for debug. It sits directly behind the PI/PO2 pad cells.

---
 rtl/simon_serial_pad_if.sv | 207 ++++++++++++++++++++
 tb/tb_simon_serial_pad_if.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/simon_serial_pad_if.sv
// simon_serial_pad_if: narrow-bus Simon 32/64 block encryptor.
// Key and plaintext arrive MS-first over an IO_W-bit input stream, the
// cipher runs one round per cycle with on-the-fly key expansion, and the
// ciphertext leaves MS-first over a matching IO_W-bit output stream.
// Handshake: a beat moves on a rising clk edge where valid and ready are
// both high; a source holds valid and payload until that edge, and ready
// never depends combinationally on valid (all outputs are registered).
module simon_serial_pad_if #(
    parameter int IO_W   = 8,
    parameter int ROUNDS = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [IO_W-1:0] in_data,
    input  logic            in_key,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [IO_W-1:0] out_data,
    output logic            out_last,
    output logic            busy
);

    localparam int KB = 64 / IO_W;
    localparam int PB = 32 / IO_W;
    localparam int CB = PB;
    localparam logic [6:0] KB_LAST = 7'(KB - 1);
    localparam logic [6:0] PB_LAST = 7'(PB - 1);
    localparam logic [6:0] CB_LAST = 7'(CB - 1);
    localparam logic [5:0] R_LAST  = 6'(ROUNDS - 1);
    // z0 sequence, bit i is the constant used when generating k[i+4]
    localparam logic [63:0] Z0 = 64'h19C3522FB386A45F;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD_KEY,
        S_LOAD_PT,
        S_RUN,
        S_UNLOAD
    } state_t;

    state_t            state_q, state_d;
    logic [63:0]       keystore_q, keystore_d;
    logic [63:0]       ksched_q, ksched_d;
    logic [31:0]       block_q, block_d;
    logic [6:0]        beat_cnt_q, beat_cnt_d;
    logic [5:0]        round_cnt_q, round_cnt_d;
    logic              in_ready_q, in_ready_d;
    logic              out_valid_q, out_valid_d;
    logic [IO_W-1:0]   out_data_q, out_data_d;
    logic              out_last_q, out_last_d;
    logic              busy_q, busy_d;

    logic              accept;
    logic              out_hs;
    logic [15:0]       rx, ry, fx, tmp, knew;
    logic [31:0]       blk_next;

    assign accept    = in_valid & in_ready_q;
    assign out_hs    = out_valid_q & out_ready;
    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_last  = out_last_q;
    assign busy      = busy_q;

    // One Simon round on the current block and the next schedule word
    always_comb begin
        rx       = block_q[31:16];
        ry       = block_q[15:0];
        fx       = ({rx[14:0], rx[15]} & {rx[7:0], rx[15:8]}) ^ {rx[13:0], rx[15:14]};
        blk_next = {ry ^ fx ^ ksched_q[15:0], rx};
        tmp      = {ksched_q[50:48], ksched_q[63:51]} ^ ksched_q[31:16];
        knew     = 16'hFFFC ^ {15'd0, Z0[round_cnt_q]} ^ ksched_q[15:0] ^ tmp ^ {tmp[0], tmp[15:1]};
    end

    // Frame sequencing: load key/plaintext, run rounds, unload ciphertext
    always_comb begin
        state_d     = state_q;
        keystore_d  = keystore_q;
        ksched_d    = ksched_q;
        block_d     = block_q;
        beat_cnt_d  = beat_cnt_q;
        round_cnt_d = round_cnt_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_last_d  = out_last_q;
        unique case (state_q)
            S_IDLE: begin
                if (accept) begin
                    beat_cnt_d = 7'd1;
                    if (in_key) begin
                        keystore_d = (keystore_q << IO_W) | 64'(in_data);
                        if (KB_LAST == 7'd0) begin
                            beat_cnt_d = 7'd0;
                            state_d    = S_LOAD_PT;
                        end else begin
                            state_d = S_LOAD_KEY;
                        end
                    end else begin
                        block_d = (block_q << IO_W) | 32'(in_data);
                        if (PB_LAST == 7'd0) begin
                            // single-beat block: straight into the rounds
                            beat_cnt_d  = 7'd0;
                            ksched_d    = keystore_q;
                            round_cnt_d = 6'd0;
                            state_d     = S_RUN;
                        end else begin
                            state_d = S_LOAD_PT;
                        end
                    end
                end
            end
            S_LOAD_KEY: begin
                if (accept) begin
                    keystore_d = (keystore_q << IO_W) | 64'(in_data);
                    if (beat_cnt_q == KB_LAST) begin
                        beat_cnt_d = 7'd0;
                        state_d    = S_LOAD_PT;
                    end else begin
                        beat_cnt_d = beat_cnt_q + 7'd1;
                    end
                end
            end
            S_LOAD_PT: begin
                if (accept) begin
                    block_d = (block_q << IO_W) | 32'(in_data);
                    if (beat_cnt_q == PB_LAST) begin
                        // working schedule always restarts from the stored key
                        beat_cnt_d  = 7'd0;
                        ksched_d    = keystore_q;
                        round_cnt_d = 6'd0;
                        state_d     = S_RUN;
                    end else begin
                        beat_cnt_d = beat_cnt_q + 7'd1;
                    end
                end
            end
            S_RUN: begin
                ksched_d = {knew, ksched_q[63:16]};
                if (round_cnt_q == R_LAST) begin
                    // present the first ciphertext beat, keep the rest shifted up
                    block_d     = blk_next << IO_W;
                    out_data_d  = blk_next[31 -: IO_W];
                    out_valid_d = 1'b1;
                    out_last_d  = (CB_LAST == 7'd0);
                    beat_cnt_d  = 7'd0;
                    round_cnt_d = 6'd0;
                    state_d     = S_UNLOAD;
                end else begin
                    block_d     = blk_next;
                    round_cnt_d = round_cnt_q + 6'd1;
                end
            end
            S_UNLOAD: begin
                if (out_hs) begin
                    if (out_last_q) begin
                        out_valid_d = 1'b0;
                        out_data_d  = '0;
                        out_last_d  = 1'b0;
                        beat_cnt_d  = 7'd0;
                        state_d     = S_IDLE;
                    end else begin
                        out_data_d = block_q[31 -: IO_W];
                        block_d    = block_q << IO_W;
                        beat_cnt_d = beat_cnt_q + 7'd1;
                        out_last_d = ((beat_cnt_q + 7'd1) == CB_LAST);
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
        in_ready_d = (state_d == S_IDLE) || (state_d == S_LOAD_KEY) || (state_d == S_LOAD_PT);
        busy_d     = (state_d != S_IDLE);
    end

    // State and datapath registers; async reset clears everything
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            keystore_q  <= '0;
            ksched_q    <= '0;
            block_q     <= '0;
            beat_cnt_q  <= '0;
            round_cnt_q <= '0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_last_q  <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            keystore_q  <= keystore_d;
            ksched_q    <= ksched_d;
            block_q     <= block_d;
            beat_cnt_q  <= beat_cnt_d;
            round_cnt_q <= round_cnt_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_last_q  <= out_last_d;
            busy_q      <= busy_d;
        end
    end

endmodule

// File: tb/tb_simon_serial_pad_if.sv
// Directed bench for simon_serial_pad_if: four builds (IO_W 8/1/32 at 32
// rounds, IO_W 8 at 1 round) driven one after another from one sequence.
module tb_simon_serial_pad_if;

    localparam logic [63:0] KEY_A = 64'h1918111009080100;
    localparam logic [31:0] PT_A  = 32'h65656877;
    localparam logic [31:0] CT_A  = 32'hC69BE9BB;

    logic       clk;
    logic       rst;
    logic [3:0] iv, ik, orr;
    logic [3:0] ir, ov, ol, bz;
    logic [7:0]  id0, id3, od0, od3;
    logic [0:0]  id1, od1;
    logic [31:0] id2, od2;

    int errors = 0;
    int checks = 0;
    logic [31:0] exp_q[$];

    simon_serial_pad_if #(.IO_W(8), .ROUNDS(32)) u0 (
        .clk(clk), .rst(rst), .in_valid(iv[0]), .in_ready(ir[0]), .in_data(id0), .in_key(ik[0]),
        .out_valid(ov[0]), .out_ready(orr[0]), .out_data(od0), .out_last(ol[0]), .busy(bz[0]));
    simon_serial_pad_if #(.IO_W(1), .ROUNDS(32)) u1 (
        .clk(clk), .rst(rst), .in_valid(iv[1]), .in_ready(ir[1]), .in_data(id1), .in_key(ik[1]),
        .out_valid(ov[1]), .out_ready(orr[1]), .out_data(od1), .out_last(ol[1]), .busy(bz[1]));
    simon_serial_pad_if #(.IO_W(32), .ROUNDS(32)) u2 (
        .clk(clk), .rst(rst), .in_valid(iv[2]), .in_ready(ir[2]), .in_data(id2), .in_key(ik[2]),
        .out_valid(ov[2]), .out_ready(orr[2]), .out_data(od2), .out_last(ol[2]), .busy(bz[2]));
    simon_serial_pad_if #(.IO_W(8), .ROUNDS(1)) u3 (
        .clk(clk), .rst(rst), .in_valid(iv[3]), .in_ready(ir[3]), .in_data(id3), .in_key(ik[3]),
        .out_valid(ov[3]), .out_ready(orr[3]), .out_data(od3), .out_last(ol[3]), .busy(bz[3]));

    // clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // reference cipher written from the textbook schedule
    function automatic logic [31:0] simon_ref(logic [63:0] key, logic [31:0] pt, int nr);
        logic [61:0] zs;
        logic [15:0] k [0:63];
        logic [15:0] x, y, t, a;
        zs = 62'b1111101000_1001010110_0001110011_0111110100_0100101011_0000111001_10;
        k[0] = key[15:0];
        k[1] = key[31:16];
        k[2] = key[47:32];
        k[3] = key[63:48];
        for (int i = 4; i < nr; i++) begin
            a = k[i-1];
            t = {a[2:0], a[15:3]} ^ k[i-3];
            k[i] = 16'hFFFC ^ {15'd0, zs[61-(i-4)]} ^ k[i-4] ^ t ^ {t[0], t[15:1]};
        end
        x = pt[31:16];
        y = pt[15:0];
        for (int i = 0; i < nr; i++) begin
            t = x;
            x = y ^ ({x[14:0], x[15]} & {x[7:0], x[15:8]}) ^ {x[13:0], x[15:14]} ^ k[i];
            y = t;
        end
        return {x, y};
    endfunction

    function automatic int wd(int u);
        case (u)
            0: return 8;
            1: return 1;
            2: return 32;
            default: return 8;
        endcase
    endfunction

    function automatic logic [31:0] odf(int u);
        case (u)
            0: return 32'(od0);
            1: return 32'(od1);
            2: return od2;
            default: return 32'(od3);
        endcase
    endfunction

    task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // driver tasks
    task automatic drive_in(int u, logic v, logic [31:0] d, logic k);
        iv[u] = v;
        ik[u] = k;
        case (u)
            0: id0 = d[7:0];
            1: id1 = d[0:0];
            2: id2 = d;
            default: id3 = d[7:0];
        endcase
    endtask

    // sends one frame; returns just after the negedge following the last accept
    task automatic send_frame(int u, logic [63:0] key, logic [31:0] pt, logic with_key, output int nacc);
        int w, total, gap, guard;
        logic [95:0] stream;
        logic [31:0] mask, beat;
        logic kflag;
        w = wd(u);
        stream = with_key ? {key, pt} : {pt, 64'd0};
        total = with_key ? (64 / w + 32 / w) : 32 / w;
        mask = (w == 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
        nacc = 0;
        for (int i = 0; i < total; i++) begin
            gap = (i == 0) ? 0 : $urandom_range(0, 2);
            repeat (gap) begin
                @(negedge clk);
                drive_in(u, 1'b0, 32'd0, 1'b0);
            end
            @(negedge clk);
            beat = 32'(stream >> (96 - w * (i + 1))) & mask;
            kflag = (i == 0) ? with_key : 1'($urandom_range(0, 1));
            drive_in(u, 1'b1, beat, kflag);
            guard = 0;
            while (!ir[u] && guard < 100) begin
                @(negedge clk);
                guard++;
            end
            if (guard >= 100) begin
                chk("send_timeout", 64'(guard), 64'd0);
                break;
            end
            @(posedge clk);
            nacc++;
        end
        @(negedge clk);
        drive_in(u, 1'b0, 32'd0, 1'b0);
    endtask

    // counts cycles from the last accept to the first out_valid
    task automatic wait_valid(int u, output int lat, output int rdy_hi);
        lat = 1;
        rdy_hi = 0;
        while (!ov[u] && lat < 300) begin
            if (ir[u]) rdy_hi++;
            @(negedge clk);
            lat++;
        end
    endtask

    // drains the ciphertext beats with out_ready held high
    task automatic collect(int u, int nb, output logic [31:0] ct, output logic [31:0] last_pat, output int nbeats);
        int w, guard;
        w = wd(u);
        ct = '0;
        last_pat = '0;
        nbeats = 0;
        orr[u] = 1'b1;
        for (int b = 0; b < nb; b++) begin
            guard = 0;
            while (!ov[u] && guard < 100) begin
                @(negedge clk);
                guard++;
            end
            if (guard >= 100) begin
                chk("collect_timeout", 64'(guard), 64'd0);
                break;
            end
            ct = (ct << w) | odf(u);
            last_pat[b] = ol[u];
            nbeats++;
            @(posedge clk);
            @(negedge clk);
        end
        orr[u] = 1'b0;
    endtask

    // stimulus and scoreboard
    initial begin
        int nacc, lat, rdy_hi, nbeats, bad;
        logic [31:0] ct, last_pat;

        rst = 1'b1;
        iv = '0; ik = '0; orr = '0;
        id0 = '0; id1 = '0; id2 = '0; id3 = '0;
        #2 rst = 1'b0;
        #1;
        chk("reset_outputs", {ov, ol, bz, ir, 32'(od0)}, 64'd0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        chk("idle_ready_busy", {ir[0], bz[0]}, 2'b10);

        // key frame, standard vector
        exp_q.push_back(CT_A);
        send_frame(0, KEY_A, PT_A, 1'b1, nacc);
        chk("w8_in_beats", 64'(nacc), 64'd12);
        wait_valid(0, lat, rdy_hi);
        chk("w8_latency", 64'(lat), 64'd33);
        chk("w8_ready_low_in_run", 64'(rdy_hi), 64'd0);
        chk("w8_first_beat", 64'(od0), 64'hC6);
        collect(0, 4, ct, last_pat, nbeats);
        chk("w8_ct", 64'(ct), 64'(exp_q.pop_front()));
        chk("w8_last_pattern", 64'(last_pat), 64'h8);
        chk("w8_idle_after", {ov[0], bz[0], ir[0]}, 3'b001);

        // key reuse frame
        exp_q.push_back(CT_A);
        send_frame(0, 64'd0, PT_A, 1'b0, nacc);
        chk("reuse_in_beats", 64'(nacc), 64'd4);
        wait_valid(0, lat, rdy_hi);
        chk("reuse_latency", 64'(lat), 64'd33);
        collect(0, 4, ct, last_pat, nbeats);
        chk("reuse_ct", 64'(ct), 64'(exp_q.pop_front()));

        // output backpressure with an input offered during the stall
        exp_q.push_back(CT_A);
        send_frame(0, 64'd0, PT_A, 1'b0, nacc);
        wait_valid(0, lat, rdy_hi);
        bad = 0;
        drive_in(0, 1'b1, 32'h5A, 1'b1);
        for (int i = 0; i < 10; i++) begin
            if (!(ov[0] === 1'b1 && od0 === 8'hC6 && ol[0] === 1'b0 && ir[0] === 1'b0)) bad++;
            @(negedge clk);
        end
        drive_in(0, 1'b0, 32'd0, 1'b0);
        chk("bp_hold_stable", 64'(bad), 64'd0);
        collect(0, 4, ct, last_pat, nbeats);
        chk("bp_ct", 64'(ct), 64'(exp_q.pop_front()));
        chk("bp_last_pattern", 64'(last_pat), 64'h8);

        // reset in RUN cycle 15
        send_frame(0, 64'd0, PT_A, 1'b0, nacc);
        repeat (14) @(negedge clk);
        chk("run_busy", {bz[0], ir[0], ov[0]}, 3'b100);
        rst = 1'b0;
        #1;
        chk("midrun_reset_outputs", {ov[0], ol[0], bz[0], ir[0], 32'(od0)}, 36'd0);
        @(negedge clk);
        rst = 1'b1;
        bad = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (ov[0] !== 1'b0) bad++;
        end
        chk("no_residual_output", 64'(bad), 64'd0);
        chk("post_reset_idle", {ir[0], bz[0]}, 2'b10);

        // reuse frame after reset: zero key
        exp_q.push_back(simon_ref(64'd0, 32'd0, 32));
        send_frame(0, 64'd0, 32'd0, 1'b0, nacc);
        wait_valid(0, lat, rdy_hi);
        chk("zero_key_latency", 64'(lat), 64'd33);
        collect(0, 4, ct, last_pat, nbeats);
        chk("zero_key_ct", 64'(ct), 64'(exp_q.pop_front()));

        // IO_W = 1
        exp_q.push_back(CT_A);
        send_frame(1, KEY_A, PT_A, 1'b1, nacc);
        chk("w1_in_beats", 64'(nacc), 64'd96);
        wait_valid(1, lat, rdy_hi);
        chk("w1_latency", 64'(lat), 64'd33);
        collect(1, 32, ct, last_pat, nbeats);
        chk("w1_out_beats", 64'(nbeats), 64'd32);
        chk("w1_ct", 64'(ct), 64'(exp_q.pop_front()));
        chk("w1_last_pattern", 64'(last_pat), 64'h8000_0000);

        // IO_W = 32
        exp_q.push_back(CT_A);
        send_frame(2, KEY_A, PT_A, 1'b1, nacc);
        chk("w32_in_beats", 64'(nacc), 64'd3);
        wait_valid(2, lat, rdy_hi);
        chk("w32_latency", 64'(lat), 64'd33);
        collect(2, 1, ct, last_pat, nbeats);
        chk("w32_ct", 64'(ct), 64'(exp_q.pop_front()));
        chk("w32_last_pattern", 64'(last_pat), 64'h1);
        exp_q.push_back(CT_A);
        send_frame(2, 64'd0, PT_A, 1'b0, nacc);
        chk("w32_reuse_in_beats", 64'(nacc), 64'd1);
        wait_valid(2, lat, rdy_hi);
        chk("w32_reuse_latency", 64'(lat), 64'd33);
        collect(2, 1, ct, last_pat, nbeats);
        chk("w32_reuse_ct", 64'(ct), 64'(exp_q.pop_front()));

        // ROUNDS = 1
        exp_q.push_back(32'h00040001);
        send_frame(3, 64'd0, 32'h00010000, 1'b1, nacc);
        wait_valid(3, lat, rdy_hi);
        chk("r1_latency", 64'(lat), 64'd2);
        collect(3, 4, ct, last_pat, nbeats);
        chk("r1_ct_hand", 64'(ct), 64'(exp_q.pop_front()));
        chk("r1_ct_model", 64'(ct), 64'(simon_ref(64'd0, 32'h00010000, 1)));
        exp_q.push_back(simon_ref(KEY_A, PT_A, 1));
        send_frame(3, KEY_A, PT_A, 1'b1, nacc);
        wait_valid(3, lat, rdy_hi);
        collect(3, 4, ct, last_pat, nbeats);
        chk("r1_keyed_ct", 64'(ct), 64'(exp_q.pop_front()));

        // final report
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
